sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 109 ++++++++++
 tb/tb_sync_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy count, almost-full /
// almost-empty thresholds and one-cycle overrun/underrun error pulses.
// Storage is a register array so it can be cleared by reset and read
// combinationally at the head pointer.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_enb,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_enb,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     fifo_almost_full,
  output logic                     fifo_almost_empty,
  output logic                     fifo_overrun,
  output logic                     fifo_underrun,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Thresholds and full level held at count width so every flag is a
  // same-width compare against the registered count.
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [CW-1:0]         count_next;
  logic                  overrun_reg;
  logic                  underrun_reg;
  logic                  wr_accept;
  logic                  rd_accept;

  // Flags decode the registered count directly, so they carry no extra latency.
  assign fifo_full         = (count_reg == FULL_CNT);
  assign fifo_empty        = (count_reg == '0);
  assign fifo_almost_full  = (count_reg >= AF_CNT);
  assign fifo_almost_empty = (count_reg <= AE_CNT);
  assign fifo_count        = count_reg;
  assign fifo_overrun      = overrun_reg;
  assign fifo_underrun     = underrun_reg;

  // A full FIFO still accepts a read and an empty one still accepts a write,
  // because each gate looks only at its own flag.
  assign wr_accept = wr_enb && !fifo_full;
  assign rd_accept = rd_enb && !fifo_empty;

  // Show-ahead: the head word is always presented; a read just advances past it.
  assign rd_data = mem_reg[rd_ptr_reg];

  // Next occupancy: simultaneous accepted read and write cancel out.
  always_comb begin
    count_next = count_reg;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Per-entry storage: each word loads only when the write pointer selects it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (wr_accept && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Pointers and count; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_accept) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  // Error pulses: set for the cycle after a request meets a blocking flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_reg  <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      overrun_reg  <= wr_enb && fifo_full;
      underrun_reg <= rd_enb && fifo_empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed-vector bench for sync_fifo at DEPTH=16, AF=14, AE=2.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_enb = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_enb = 1'b0;
  logic [7:0] rd_data;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_almost_full;
  logic       fifo_almost_empty;
  logic       fifo_overrun;
  logic       fifo_underrun;
  logic [4:0] fifo_count;

  int vectors = 0;
  int miscompares = 0;

  sync_fifo #(
    .DATA_WIDTH(8),
    .DEPTH(16),
    .AF_LEVEL(14),
    .AE_LEVEL(2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_enb           (wr_enb),
    .wr_data          (wr_data),
    .rd_enb           (rd_enb),
    .rd_data          (rd_data),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .fifo_almost_full (fifo_almost_full),
    .fifo_almost_empty(fifo_almost_empty),
    .fifo_overrun     (fifo_overrun),
    .fifo_underrun    (fifo_underrun),
    .fifo_count       (fifo_count)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every vector, reports any miscompare.
  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full output snapshot against hand-written expectations.
  task automatic check_state(input string tag, input int cnt, input logic full, input logic af,
                             input logic ae, input logic empty);
    check_vec({tag, ".count"}, 32'(fifo_count), 32'(cnt));
    check_vec({tag, ".full"},  32'(fifo_full), 32'(full));
    check_vec({tag, ".af"},    32'(fifo_almost_full), 32'(af));
    check_vec({tag, ".ae"},    32'(fifo_almost_empty), 32'(ae));
    check_vec({tag, ".empty"}, 32'(fifo_empty), 32'(empty));
  endtask

  // Expected flag columns for scenario 1 after writes 1..16 (count = index+1).
  logic [15:0] s1_af = 16'b1110_0000_0000_0000; // af at counts 14,15,16
  logic [15:0] s1_ae = 16'b0000_0000_0000_0011; // ae at counts 1,2

  initial begin
    // Reset state, with requests held active during reset.
    wr_enb = 1'b1; rd_enb = 1'b1; wr_data = 8'h99;
    #2;
    step();
    step();
    check_state("rst", 0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_vec("rst.rd_data", 32'(rd_data), 32'h00);
    check_vec("rst.overrun", 32'(fifo_overrun), 32'h0);
    check_vec("rst.underrun", 32'(fifo_underrun), 32'h0);
    rst = 1'b0; wr_enb = 1'b0; rd_enb = 1'b0;
    step();
    check_vec("rel.underrun", 32'(fifo_underrun), 32'h0);
    check_vec("rel.count", 32'(fifo_count), 32'h0);

    // Scenario 1: fill with 0x01..0x10.
    for (int i = 0; i < 16; i++) begin
      wr_enb = 1'b1; wr_data = 8'(i + 1);
      step();
      check_state($sformatf("s1.w%0d", i), i + 1, (i == 15), s1_af[i], s1_ae[i], 1'b0);
      check_vec($sformatf("s1.head%0d", i), 32'(rd_data), 32'h01);
    end

    // Scenario 2: overrun while full, then drain in order.
    wr_data = 8'hAA;
    step();
    wr_enb = 1'b0;
    check_vec("s2.overrun", 32'(fifo_overrun), 32'h1);
    check_vec("s2.count", 32'(fifo_count), 32'd16);
    step();
    check_vec("s2.overrun_clr", 32'(fifo_overrun), 32'h0);
    for (int i = 0; i < 16; i++) begin
      rd_enb = 1'b1;
      check_vec($sformatf("s2.rd%0d", i), 32'(rd_data), 32'(i + 1));
      step();
    end
    rd_enb = 1'b0;
    check_state("s2.end", 0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Scenario 3: underrun while empty.
    rd_enb = 1'b1;
    step();
    rd_enb = 1'b0;
    check_vec("s3.underrun", 32'(fifo_underrun), 32'h1);
    check_vec("s3.count", 32'(fifo_count), 32'h0);
    step();
    check_vec("s3.underrun_clr", 32'(fifo_underrun), 32'h0);

    // Scenario 4: count 5, 20 cycles of simultaneous read/write.
    for (int i = 0; i < 5; i++) begin
      wr_enb = 1'b1; wr_data = 8'(8'h20 + i);
      step();
    end
    check_vec("s4.head", 32'(rd_data), 32'h20);
    for (int k = 0; k < 20; k++) begin
      wr_enb = 1'b1; rd_enb = 1'b1; wr_data = 8'(8'h25 + k);
      check_vec($sformatf("s4.rd%0d", k), 32'(rd_data), 32'(8'h20 + k));
      step();
      check_vec($sformatf("s4.cnt%0d", k), 32'(fifo_count), 32'd5);
    end
    wr_enb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_enb = 1'b1;
      check_vec($sformatf("s4.drain%0d", i), 32'(rd_data), 32'(8'h34 + i));
      step();
    end
    rd_enb = 1'b0;
    check_state("s4.end", 0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Scenario 5a: simultaneous read/write while full.
    for (int i = 0; i < 16; i++) begin
      wr_enb = 1'b1; wr_data = 8'(8'h40 + i);
      step();
    end
    wr_enb = 1'b1; rd_enb = 1'b1; wr_data = 8'hEE;
    check_vec("s5.full_head", 32'(rd_data), 32'h40);
    step();
    wr_enb = 1'b0; rd_enb = 1'b0;
    check_vec("s5.full_count", 32'(fifo_count), 32'd15);
    check_vec("s5.full_overrun", 32'(fifo_overrun), 32'h1);
    for (int i = 1; i < 16; i++) begin
      rd_enb = 1'b1;
      check_vec($sformatf("s5.drain%0d", i), 32'(rd_data), 32'(8'h40 + i));
      step();
    end
    rd_enb = 1'b0;
    check_vec("s5.drained_empty", 32'(fifo_empty), 32'h1);

    // Scenario 5b: simultaneous read/write while empty.
    wr_enb = 1'b1; rd_enb = 1'b1; wr_data = 8'h77;
    step();
    wr_enb = 1'b0; rd_enb = 1'b0;
    check_vec("s5.empty_count", 32'(fifo_count), 32'd1);
    check_vec("s5.empty_underrun", 32'(fifo_underrun), 32'h1);
    check_vec("s5.empty_head", 32'(rd_data), 32'h77);
    rd_enb = 1'b1;
    step();
    rd_enb = 1'b0;

    // Scenario 6: mid-cycle asynchronous reset at count 9.
    for (int i = 0; i < 9; i++) begin
      wr_enb = 1'b1; wr_data = 8'(8'h60 + i);
      step();
    end
    wr_enb = 1'b0;
    check_vec("s6.pre_count", 32'(fifo_count), 32'd9);
    #2 rst = 1'b1;
    #1;
    check_state("s6.async", 0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_vec("s6.rd_data", 32'(rd_data), 32'h00);
    step();
    rst = 1'b0;
    wr_enb = 1'b1; wr_data = 8'h5C;
    step();
    wr_enb = 1'b0;
    check_vec("s6.head", 32'(rd_data), 32'h5C);
    check_vec("s6.count", 32'(fifo_count), 32'd1);
    wr_enb = 1'b1; wr_data = 8'h5D;
    step();
    wr_enb = 1'b0; rd_enb = 1'b1;
    check_vec("s6.entry0", 32'(rd_data), 32'h5C);
    step();
    rd_enb = 1'b0;
    check_vec("s6.entry1", 32'(rd_data), 32'h5D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
